f1_start_seq: RTL and testbench

- Consumer of the 4-bit LFSR stage: drives the 8-light start-gantry sequence, then holds all lights for a pseudo-random number of ticks taken from the LFSR output.
- After lights-out, measures the operator's reaction time in clock cycles.
- Owns the LFSR enable, so the random value is frozen while it is in use.
- Sits between the LFSR and the display/readout logic.

---
 rtl/f1_start_seq.sv | 164 ++++++++++++++++
 tb/tb_f1_start_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/f1_start_seq.sv
// f1_start_seq: start-gantry sequencer with a reaction-time counter.
//
// It steps eight lights on, one per tick, then holds all eight for a number
// of ticks taken from the LFSR (0 is treated as 1). It then turns the lights
// out and counts clk cycles until the operator reacts. A react during the
// lights or the hold is reported as a false start. The LFSR is enabled only
// while idle, so the delay value stays stable for the whole run.
//
// Ports:
//   clk          clock
//   rst          synchronous, active-high reset
//   trigger      start request, sampled in IDLE only
//   rnd[3:0]     LFSR output, used as the hold delay in ticks
//   react        operator response (level)
//   lfsr_en      LFSR enable, high only in IDLE
//   lights[7:0]  gantry lights, bit0 lights first
//   react_time   last measured reaction time in clk cycles (RT_W bits)
//   time_valid   one-cycle pulse when react_time updates
//   false_start  one-cycle pulse on a react before lights-out
module f1_start_seq #(
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned RT_W     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trigger,
    input  logic [3:0]      rnd,
    input  logic            react,
    output logic            lfsr_en,
    output logic [7:0]      lights,
    output logic [RT_W-1:0] react_time,
    output logic            time_valid,
    output logic            false_start
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LIGHTS,
        S_HOLD,
        S_REACT
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0]      lights_q, lights_d;
    logic [3:0]      hold_q, hold_d;
    logic [RT_W-1:0] rt_q, rt_d;
    logic [RT_W-1:0] react_time_q, react_time_d;
    logic            tv_q, tv_d;
    logic            fs_q, fs_d;
    logic            en_q, en_d;
    logic            tick;

    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        lights_d     = lights_q;
        hold_d       = hold_q;
        rt_d         = rt_q;
        react_time_d = react_time_q;
        tv_d         = 1'b0;
        fs_d         = 1'b0;

        case (state_q)
            S_IDLE: begin
                presc_d  = '0;
                lights_d = '0;
                if (trigger) begin
                    state_d  = S_LIGHTS;
                    lights_d = 8'h01;
                end
            end

            S_LIGHTS: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                // A false start wins over a coincident tick.
                if (react) begin
                    state_d  = S_IDLE;
                    lights_d = '0;
                    fs_d     = 1'b1;
                end else if (tick) begin
                    if (lights_q == 8'hFF) begin
                        state_d = S_HOLD;
                        hold_d  = (rnd == 4'd0) ? 4'd1 : rnd;
                    end else begin
                        lights_d = {lights_q[6:0], 1'b1};
                    end
                end
            end

            S_HOLD: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (react) begin
                    state_d  = S_IDLE;
                    lights_d = '0;
                    fs_d     = 1'b1;
                end else if (tick) begin
                    if (hold_q == 4'd1) begin
                        state_d  = S_REACT;
                        lights_d = '0;
                        rt_d     = '0;
                    end else begin
                        hold_d = hold_q - 4'd1;
                    end
                end
            end

            S_REACT: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (react) begin
                    state_d      = S_IDLE;
                    react_time_d = rt_q;
                    tv_d         = 1'b1;
                end else if (rt_q != '1) begin
                    rt_d = rt_q + 1'b1;
                end
            end

            default: begin
                state_d  = S_IDLE;
                lights_d = '0;
            end
        endcase

        // Registered from the next state so the enable lines up with IDLE.
        en_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            presc_q      <= '0;
            lights_q     <= '0;
            hold_q       <= '0;
            rt_q         <= '0;
            react_time_q <= '0;
            tv_q         <= 1'b0;
            fs_q         <= 1'b0;
            en_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            lights_q     <= lights_d;
            hold_q       <= hold_d;
            rt_q         <= rt_d;
            react_time_q <= react_time_d;
            tv_q         <= tv_d;
            fs_q         <= fs_d;
            en_q         <= en_d;
        end
    end

    assign lfsr_en     = en_q;
    assign lights      = lights_q;
    assign react_time  = react_time_q;
    assign time_valid  = tv_q;
    assign false_start = fs_q;

endmodule

// File: tb/tb_f1_start_seq.sv
module tb_f1_start_seq;

    localparam int unsigned TD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        trigger;
    logic [3:0]  rnd;
    logic        react;

    logic        a_en, a_tv, a_fs;
    logic [7:0]  a_lights;
    logic [15:0] a_rt;
    logic        b_en, b_tv, b_fs;
    logic [7:0]  b_lights;
    logic [3:0]  b_rt;

    int unsigned nvec = 0;
    int unsigned nbad = 0;

    always #5 clk = ~clk;

    f1_start_seq #(.TICK_DIV(TD), .RT_W(16)) u_dut (
        .clk(clk), .rst(rst), .trigger(trigger), .rnd(rnd), .react(react),
        .lfsr_en(a_en), .lights(a_lights), .react_time(a_rt),
        .time_valid(a_tv), .false_start(a_fs)
    );

    // Narrow reaction counter to exercise saturation.
    f1_start_seq #(.TICK_DIV(TD), .RT_W(4)) u_dut_narrow (
        .clk(clk), .rst(rst), .trigger(trigger), .rnd(rnd), .react(react),
        .lfsr_en(b_en), .lights(b_lights), .react_time(b_rt),
        .time_valid(b_tv), .false_start(b_fs)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Light pattern after n ticks in LIGHTS.
    function automatic logic [7:0] bar(input int n);
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < 8; i++)
            if (i <= n) v[i] = 1'b1;
        return v;
    endfunction

    initial begin
        rst = 1'b1; trigger = 1'b0; react = 1'b0; rnd = 4'd5;
        step(); step();
        chk("rst_lights", a_lights, 8'h00);
        chk("rst_en", a_en, 1'b1);
        chk("rst_rt", a_rt, 16'd0);
        chk("rst_tv", a_tv, 1'b0);
        chk("rst_fs", a_fs, 1'b0);
        rst = 1'b0;
        react = 1'b1;              // ignored in IDLE
        step();
        chk("idle_react_fs", a_fs, 1'b0);
        chk("idle_en", a_en, 1'b1);
        react = 1'b0;

        // Full run, D=5: lights-out at E0+52, react after 10 cycles.
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        chk("e0_lights", a_lights, 8'h01);
        chk("e0_en", a_en, 1'b0);
        for (int k = 1; k <= 51; k++) begin
            step();
            if (k == 33) rnd = 4'd2;   // latched value must still be 5
            if (k % 4 == 0 || k % 4 == 3) chk("bar", a_lights, bar(k / 4));
        end
        chk("hold_en", a_en, 1'b0);
        step();
        chk("out_52", a_lights, 8'h00);
        for (int c = 0; c < 10; c++) begin
            trigger = (c == 3);        // trigger in REACT has no effect
            step();
        end
        trigger = 1'b0;
        chk("react_tv_low", a_tv, 1'b0);
        react = 1'b1;
        step();
        react = 1'b0;
        chk("rt_10", a_rt, 16'd10);
        chk("tv_pulse", a_tv, 1'b1);
        chk("en_back", a_en, 1'b1);
        chk("narrow_rt_10", b_rt, 4'd10);
        step();
        chk("tv_end", a_tv, 1'b0);
        chk("idle_lights", a_lights, 8'h00);

        // False start coinciding with a tick while lights=07.
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        for (int k = 1; k <= 11; k++) step();
        chk("fs_pre_lights", a_lights, 8'h07);
        react = 1'b1;
        step();
        react = 1'b0;
        chk("fs_pulse", a_fs, 1'b1);
        chk("fs_lights", a_lights, 8'h00);
        chk("fs_rt_keep", a_rt, 16'd10);
        chk("fs_tv", a_tv, 1'b0);
        chk("fs_en", a_en, 1'b1);
        step();
        chk("fs_end", a_fs, 1'b0);
        chk("fs_idle", a_lights, 8'h00);

        // rnd=0 acts as one tick; trigger held high restarts at once.
        rnd = 4'd0;
        trigger = 1'b1;
        step();
        for (int k = 1; k <= 35; k++) step();
        chk("r0_ff", a_lights, 8'hFF);
        step();
        chk("r0_out_36", a_lights, 8'h00);
        react = 1'b1;
        step();
        react = 1'b0;
        chk("first_cycle_rt", a_rt, 16'd0);
        chk("first_cycle_tv", a_tv, 1'b1);
        chk("first_cycle_en", a_en, 1'b1);
        step();
        trigger = 1'b0;
        chk("restart_lights", a_lights, 8'h01);
        chk("restart_en", a_en, 1'b0);

        // Saturation on the narrow counter.
        for (int k = 1; k <= 36; k++) step();
        chk("sat_out", a_lights, 8'h00);
        for (int c = 0; c < 20; c++) step();
        react = 1'b1;
        step();
        react = 1'b0;
        chk("sat_narrow", b_rt, 4'hF);
        chk("sat_wide", a_rt, 16'd20);
        chk("sat_tv", b_tv, 1'b1);
        step();

        // Reset in HOLD.
        rnd = 4'd3;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        for (int k = 1; k <= 40; k++) step();
        chk("hold_ff", a_lights, 8'hFF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("hrst_lights", a_lights, 8'h00);
        chk("hrst_en", a_en, 1'b1);
        chk("hrst_rt", a_rt, 16'd0);
        chk("hrst_tv", a_tv, 1'b0);
        chk("hrst_fs", a_fs, 1'b0);
        for (int k = 0; k < 12; k++) step();
        chk("hrst_stay", a_lights, 8'h00);
        chk("hrst_stay_en", a_en, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
